// File: rtl/fir_tdm_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed multichannel FIR.
// The output helper works on a wide signed value so any AW/OW combination fits.
package fir_tdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int SAT_W = 128;

  function automatic int acc_width(input int iw, input int tw, input int ntaps);
    return iw + tw + $clog2(ntaps) + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] shift_sat(
    input logic signed [SAT_W-1:0] acc,
    input int                      shift,
    input int                      ow,
    input logic                    sat
  );
    logic signed [SAT_W-1:0] shifted_s;
    logic signed [SAT_W-1:0] max_s;
    logic signed [SAT_W-1:0] min_s;
    logic signed [SAT_W-1:0] res_s;
    shifted_s = acc >>> shift;
    max_s     = (128'sd1 <<< (ow - 1)) - 128'sd1;
    min_s     = -(128'sd1 <<< (ow - 1));
    if (sat) begin
      if (shifted_s > max_s) begin
        res_s = max_s;
      end else if (shifted_s < min_s) begin
        res_s = min_s;
      end else begin
        res_s = shifted_s;
      end
    end else begin
      // Caller keeps only the low OW bits, which gives the wrap behaviour.
      res_s = shifted_s;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/fir_tdm_mac.sv
// Registered signed multiply-accumulate with synchronous clear; one product per enabled cycle.
module fir_tdm_mac #(
  parameter int IW = 12,
  parameter int TW = 12,
  parameter int AW = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [IW-1:0] sample,
  input  logic signed [TW-1:0] coef,
  output logic signed [AW-1:0] acc
);

  logic signed [IW+TW-1:0] prod_s;
  logic signed [AW-1:0]    acc_r;

  assign prod_s = sample * coef;
  assign acc    = acc_r;

  // Accumulator register: clear has priority over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {AW{1'b0}};
    end else if (clr) begin
      acc_r <= {AW{1'b0}};
    end else if (en) begin
      acc_r <= acc_r + AW'(prod_s);
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/fir_tdm_multichan.sv
// Multichannel signed FIR sharing one MAC (one tap per clock), runtime-loadable taps,
// valid/ready on both sample input and result output.
module fir_tdm_multichan
  import fir_tdm_pkg::*;
#(
  parameter int NTAPS = 5,
  parameter int NCH   = 2,
  parameter int IW    = 12,
  parameter int TW    = 12,
  parameter int OW    = 2 * IW + 7,
  parameter int SHIFT = 0,
  parameter int SAT   = 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic signed [IW-1:0]                   i_sample,
  input  logic [$clog2((NCH > 1) ? NCH : 2)-1:0] i_ch,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic signed [OW-1:0]                   o_result,
  output logic [$clog2((NCH > 1) ? NCH : 2)-1:0] o_ch,
  input  logic                                   i_tap_wr,
  input  logic [$clog2(NTAPS)-1:0]               i_tap_addr,
  input  logic signed [TW-1:0]                   i_tap_data,
  output logic                                   o_tap_ready
);

  localparam int CW  = $clog2((NCH > 1) ? NCH : 2);
  localparam int TAW = $clog2(NTAPS);
  localparam int KW  = $clog2(NTAPS + 1);
  localparam int AW  = acc_width(IW, TW, NTAPS);

  state_t               state_r;
  logic [KW-1:0]        k_r;
  logic [CW-1:0]        ch_r;
  logic                 o_valid_r;
  logic signed [OW-1:0] o_result_r;
  logic [CW-1:0]        o_ch_r;

  logic signed [TW-1:0] taps_r  [NTAPS];
  logic signed [IW-1:0] dline_r [NCH][NTAPS];

  logic                 idle_s;
  logic                 accept_s;
  logic                 ch_ok_s;
  logic                 shift_en_s;
  logic                 tap_we_s;
  logic                 mac_en_s;
  logic [TAW-1:0]       k_idx_s;
  logic signed [TW-1:0] coef_s;
  logic signed [IW-1:0] samp_s;
  logic signed [AW-1:0] acc_s;

  assign idle_s      = (state_r == ST_IDLE);
  assign o_ready     = idle_s && !i_tap_wr;
  assign o_tap_ready = idle_s;
  assign accept_s    = idle_s && i_valid && !i_tap_wr;
  assign ch_ok_s     = (int'(i_ch) < NCH);
  assign shift_en_s  = accept_s && ch_ok_s;
  assign tap_we_s    = idle_s && i_tap_wr && (int'(i_tap_addr) < NTAPS);
  assign mac_en_s    = (state_r == ST_MAC) && (int'(k_r) < NTAPS);
  assign k_idx_s     = k_r[TAW-1:0];

  assign o_valid  = o_valid_r;
  assign o_result = o_result_r;
  assign o_ch     = o_ch_r;

  // Operand select for the current tap; zero once the tap index runs past the end.
  always_comb begin
    coef_s = {TW{1'b0}};
    samp_s = {IW{1'b0}};
    if (mac_en_s) begin
      coef_s = taps_r[k_idx_s];
      samp_s = dline_r[ch_r][k_idx_s];
    end else begin
      coef_s = {TW{1'b0}};
      samp_s = {IW{1'b0}};
    end
  end

  fir_tdm_mac #(
    .IW(IW),
    .TW(TW),
    .AW(AW)
  ) u_mac (
    .clk    (i_clk),
    .rst    (i_reset),
    .clr    (shift_en_s),
    .en     (mac_en_s),
    .sample (samp_s),
    .coef   (coef_s),
    .acc    (acc_s)
  );

  // Coefficient register file, writable only while idle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        taps_r[k] <= {TW{1'b0}};
      end
    end else if (tap_we_s) begin
      taps_r[i_tap_addr] <= i_tap_data;
    end
  end

  // Per-channel delay lines; only the addressed channel shifts on acceptance.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < NTAPS; k++) begin
          dline_r[c][k] <= {IW{1'b0}};
        end
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (shift_en_s && (int'(i_ch) == c)) begin
          dline_r[c][0] <= i_sample;
          for (int k = 1; k < NTAPS; k++) begin
            dline_r[c][k] <= dline_r[c][k-1];
          end
        end
      end
    end
  end

  // Control FSM with registered result outputs. MAC runs NTAPS accumulate cycles
  // plus one cycle to register the shifted/saturated result.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      k_r        <= {KW{1'b0}};
      ch_r       <= {CW{1'b0}};
      o_valid_r  <= 1'b0;
      o_result_r <= {OW{1'b0}};
      o_ch_r     <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (shift_en_s) begin
            state_r <= ST_MAC;
            k_r     <= {KW{1'b0}};
            ch_r    <= i_ch;
          end
        end
        ST_MAC: begin
          if (k_r == KW'(NTAPS)) begin
            o_result_r <= OW'(shift_sat(SAT_W'(acc_s), SHIFT, OW, (SAT != 0)));
            o_ch_r     <= ch_r;
            o_valid_r  <= 1'b1;
            state_r    <= ST_OUT;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        ST_OUT: begin
          if (i_ready) begin
            o_valid_r <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          o_valid_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tdm_multichan.sv
// Self-checking bench: table-driven vectors plus hand sequences, scoreboard on the result port.
module tb_fir_tdm_multichan;

  localparam int NTAPS = 5;
  localparam int NCH   = 2;
  localparam int IW    = 12;
  localparam int TW    = 12;
  localparam int OW    = 2 * IW + 7;

  logic                 clk = 1'b0;
  logic                 i_reset;
  logic                 i_valid;
  logic signed [IW-1:0] i_sample;
  logic [0:0]           i_ch;
  logic                 i_ready;
  logic                 i_tap_wr;
  logic [2:0]           i_tap_addr;
  logic signed [TW-1:0] i_tap_data;

  logic                 o_ready, o_valid, o_tap_ready;
  logic signed [OW-1:0] o_result;
  logic [0:0]           o_ch;
  logic                 s_ready, s_valid, s_tap_ready;
  logic signed [15:0]   s_result;
  logic [0:0]           s_ch;
  logic                 w_ready, w_valid, w_tap_ready;
  logic signed [15:0]   w_result;
  logic [0:0]           w_ch;

  always #5 clk = ~clk;

  fir_tdm_multichan #(.NTAPS(NTAPS), .NCH(NCH), .IW(IW), .TW(TW), .OW(OW), .SHIFT(0), .SAT(1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready), .i_sample(i_sample),
    .i_ch(i_ch), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_ch(o_ch),
    .i_tap_wr(i_tap_wr), .i_tap_addr(i_tap_addr), .i_tap_data(i_tap_data), .o_tap_ready(o_tap_ready));

  fir_tdm_multichan #(.NTAPS(NTAPS), .NCH(NCH), .IW(IW), .TW(TW), .OW(16), .SHIFT(0), .SAT(1)) dut_sat (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(s_ready), .i_sample(i_sample),
    .i_ch(i_ch), .o_valid(s_valid), .i_ready(i_ready), .o_result(s_result), .o_ch(s_ch),
    .i_tap_wr(i_tap_wr), .i_tap_addr(i_tap_addr), .i_tap_data(i_tap_data), .o_tap_ready(s_tap_ready));

  fir_tdm_multichan #(.NTAPS(NTAPS), .NCH(NCH), .IW(IW), .TW(TW), .OW(16), .SHIFT(0), .SAT(0)) dut_wrap (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(w_ready), .i_sample(i_sample),
    .i_ch(i_ch), .o_valid(w_valid), .i_ready(i_ready), .o_result(w_result), .o_ch(w_ch),
    .i_tap_wr(i_tap_wr), .i_tap_addr(i_tap_addr), .i_tap_data(i_tap_data), .o_tap_ready(w_tap_ready));

  typedef struct {
    int     ch;
    longint val;
  } exp_t;

  typedef struct {
    int     ch;
    int     x;
    longint y;
  } vec_t;

  int     errors = 0;
  int     checks = 0;
  exp_t   sb_q[$];
  longint m_taps[NTAPS];
  longint m_dl[NCH][NTAPS];
  vec_t   vecs[14];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model_push(input int ch, input longint x);
    longint y;
    for (int k = NTAPS - 1; k > 0; k--) m_dl[ch][k] = m_dl[ch][k-1];
    m_dl[ch][0] = x;
    y = 0;
    for (int k = 0; k < NTAPS; k++) y += m_taps[k] * m_dl[ch][k];
    return y;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NTAPS; k++) begin
      m_taps[k] = 0;
      for (int c = 0; c < NCH; c++) m_dl[c][k] = 0;
    end
  endtask

  // Result monitor: compares on each output handshake (inputs settle at negedge).
  always @(negedge clk) begin
    #2;
    if (!i_reset && o_valid && i_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", longint'(o_result), e.val);
        check("result_ch", longint'(o_ch), longint'(e.ch));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input int ch, input longint x, input bit use_tbl, input longint tbl_y);
    bit     ok;
    exp_t   e;
    longint y;
    logic signed [63:0] xv;
    xv = x;
    i_valid = 1'b1;
    i_sample = xv[IW-1:0];
    i_ch = ch[0:0];
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", longint'(ok), 1);
    @(posedge clk);
    y = model_push(ch, x);
    e.ch = ch;
    e.val = use_tbl ? tbl_y : y;
    sb_q.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic write_tap(input int addr, input int data);
    logic [31:0] av;
    logic [31:0] dv;
    av = addr;
    dv = data;
    i_tap_wr = 1'b1;
    i_tap_addr = av[2:0];
    i_tap_data = dv[TW-1:0];
    @(posedge clk);
    if (addr < NTAPS) m_taps[addr] = longint'(data);
    @(negedge clk);
    i_tap_wr = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("drain_timeout", longint'(done), 1);
    @(negedge clk);
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (o_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("valid_timeout", longint'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit     seen;
    int     lat;
    longint held_r;
    longint held_c;

    vecs[0]  = '{0, 1, 1};   vecs[1]  = '{0, 0, 2};   vecs[2]  = '{0, 0, 3};
    vecs[3]  = '{0, 0, 4};   vecs[4]  = '{0, 0, 5};   vecs[5]  = '{0, 0, 0};
    vecs[6]  = '{0, 1, 1};   vecs[7]  = '{1, 7, 7};   vecs[8]  = '{0, 0, 2};
    vecs[9]  = '{1, 7, 21};  vecs[10] = '{0, 0, 3};   vecs[11] = '{1, 7, 42};
    vecs[12] = '{0, -3, 1};  vecs[13] = '{1, 100, 163};

    model_clear();
    i_reset = 1'b1; i_valid = 1'b0; i_sample = '0; i_ch = '0; i_ready = 1'b1;
    i_tap_wr = 1'b0; i_tap_addr = '0; i_tap_data = '0;
    repeat (3) @(negedge clk);
    check("rst_o_valid", longint'(o_valid), 0);
    check("rst_o_result", longint'(o_result), 0);
    check("rst_o_ch", longint'(o_ch), 0);
    i_reset = 1'b0;
    #1;
    check("rst_o_ready", longint'(o_ready), 1);
    check("rst_o_tap_ready", longint'(o_tap_ready), 1);
    @(negedge clk);

    for (int k = 0; k < NTAPS; k++) write_tap(k, k + 1);

    // Impulse, channel interleave and mixed-sign vectors from the table.
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].ch, longint'(vecs[i].x), 1'b1, vecs[i].y);
      if (i == 0) begin
        lat = 0;
        while (!o_valid && lat < 50) begin
          @(negedge clk);
          lat++;
        end
        check("latency", longint'(lat), longint'(NTAPS + 1));
      end
    end
    drain();

    // Backpressure: output held stable while downstream stalls.
    i_ready = 1'b0;
    send(1, 5, 1'b0, 0);
    wait_valid(seen);
    held_r = longint'(o_result);
    held_c = longint'(o_ch);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp_valid", longint'(o_valid), 1);
      check("bp_result", longint'(o_result), held_r);
      check("bp_ch", longint'(o_ch), held_c);
      check("bp_o_ready", longint'(o_ready), 0);
    end
    i_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_o_ready", longint'(o_ready), 1);
    @(negedge clk);

    // Tap write during MAC is refused and ignored.
    send(0, 2, 1'b0, 0);
    i_tap_wr = 1'b1; i_tap_addr = 3'd0; i_tap_data = 12'sd99;
    #1;
    check("mac_tap_ready", longint'(o_tap_ready), 0);
    @(negedge clk);
    i_tap_wr = 1'b0;
    drain();
    send(0, 1, 1'b0, 0);
    drain();

    // Simultaneous write and sample in IDLE: write wins, sample not taken.
    i_tap_wr = 1'b1; i_tap_addr = 3'd4; i_tap_data = 12'sd6;
    i_valid = 1'b1; i_sample = 12'sd50; i_ch = 1'b0;
    #1;
    check("both_o_ready", longint'(o_ready), 0);
    check("both_tap_ready", longint'(o_tap_ready), 1);
    @(posedge clk);
    m_taps[4] = 6;
    @(negedge clk);
    i_tap_wr = 1'b0; i_valid = 1'b0;
    #1;
    check("both_still_idle", longint'(o_ready), 1);
    repeat (8) @(negedge clk);
    send(1, 3, 1'b0, 0);
    send(0, -1, 1'b0, 0);
    drain();

    // Reset in the middle of MAC discards the in-flight result.
    send(0, 9, 1'b0, 0);
    @(negedge clk);
    i_reset = 1'b1;
    sb_q.delete();
    model_clear();
    for (int n = 0; n < NTAPS + 3; n++) begin
      @(negedge clk);
      check("midrst_valid", longint'(o_valid), 0);
    end
    check("midrst_result", longint'(o_result), 0);
    check("midrst_ch", longint'(o_ch), 0);
    i_reset = 1'b0;
    #1;
    check("midrst_o_ready", longint'(o_ready), 1);
    check("midrst_tap_ready", longint'(o_tap_ready), 1);
    @(negedge clk);
    send(0, 1, 1'b1, 0);
    send(0, 0, 1'b1, 0);
    drain();
    for (int k = 0; k < NTAPS; k++) write_tap(k, k + 1);
    send(0, 0, 1'b1, 3);
    send(1, 0, 1'b1, 0);
    drain();

    // Saturation / wrap on the 16-bit instances.
    for (int k = 0; k < NTAPS; k++) write_tap(k, 2047);
    for (int n = 0; n < 5; n++) send(0, -2048, 1'b0, 0);
    wait_valid(seen);
    check("sat16_result", longint'(s_result), -32768);
    check("wrap16_result", longint'(w_result), 10240);
    check("full_result", longint'(o_result), -20961280);
    drain();

    check("sb_empty", longint'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
